// File: rtl/gm_defs.sv
// Shared game definitions: stone RAM word layout, type codes, screen size,
// sprite geometry, default palette and the stone drawer FSM states.
package gm_defs;

    // Stone RAM word fields
    localparam int unsigned X_MSB    = 31;
    localparam int unsigned X_LSB    = 23;
    localparam int unsigned Y_MSB    = 18;
    localparam int unsigned Y_LSB    = 11;
    localparam int unsigned TYPE_MSB = 3;
    localparam int unsigned TYPE_LSB = 2;
    localparam int unsigned VIS_BIT  = 1;
    localparam int unsigned MOV_BIT  = 0;

    // Stone type codes; 2'b11 renders as diamond as well
    localparam logic [1:0] TYPE_STONE   = 2'b00;
    localparam logic [1:0] TYPE_GOLD    = 2'b01;
    localparam logic [1:0] TYPE_DIAMOND = 2'b10;

    // Visible screen and sprite geometry
    localparam int unsigned SCR_W       = 320;
    localparam int unsigned SCR_H       = 240;
    localparam int unsigned SPRITE_SIZE = 16;

    // Default palette
    localparam logic [2:0] DEF_COL_STONE   = 3'b110;
    localparam logic [2:0] DEF_COL_GOLD    = 3'b110;
    localparam logic [2:0] DEF_COL_DIAMOND = 3'b011;
    localparam logic [2:0] DEF_COL_OUTLINE = 3'b000;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StAddr,
        StWait,
        StLatch,
        StPlot,
        StNext,
        StDone
    } drawer_state_e;

    // Screen-space pixel test on the widened sums so off-screen carries never wrap
    function automatic logic in_screen(logic [9:0] xs, logic [8:0] ys);
        return (xs < 10'(SCR_W)) && (ys < 9'(SCR_H));
    endfunction

endpackage

// File: rtl/sprite_scan.sv
// Raster counter for one 16x16 sprite: px runs fastest, py steps when px wraps.
// last flags the final pixel, border flags pixels on the sprite's outer ring.
module sprite_scan
    import gm_defs::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       clear,
    input  logic       go,
    output logic [3:0] px,
    output logic [3:0] py,
    output logic       last,
    output logic       border
);

    localparam logic [3:0] SprMax = 4'(SPRITE_SIZE - 1);

    // Counter pair: clear restarts the raster, go advances one pixel
    always_ff @(posedge clock) begin
        if (!resetn) begin
            px <= '0;
            py <= '0;
        end else if (clear) begin
            px <= '0;
            py <= '0;
        end else if (go) begin
            px <= px + 4'd1;
            if (px == SprMax) begin
                py <= py + 4'd1;
            end
        end
    end

    // Raster position flags
    always_comb begin
        last   = (px == SprMax) && (py == SprMax);
        border = (px == 4'd0) || (px == SprMax) || (py == 4'd0) || (py == SprMax);
    end

endmodule

// File: rtl/stone_drawer.sv
// Per-frame stone renderer: walks stone RAM entries through the rope block's
// read port and streams each visible stone as a clipped 16x16 sprite.
// Optional build macro: STONE_DRAWER_OUTLINE_EN (draws sprite border in COL_OUTLINE).
module stone_drawer
    import gm_defs::*;
#(
    parameter logic [2:0] COL_STONE   = DEF_COL_STONE,
    parameter logic [2:0] COL_GOLD    = DEF_COL_GOLD,
    parameter logic [2:0] COL_DIAMOND = DEF_COL_DIAMOND,
    parameter logic [2:0] COL_OUTLINE = DEF_COL_OUTLINE
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [3:0]  quantity,
    input  logic [31:0] data,
    output logic        draw_stone_flag,
    output logic [3:0]  draw_index,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    drawer_state_e state_q, state_d;
    logic [3:0] qty_q, qty_d;
    logic [3:0] idx_q, idx_d;
    logic [8:0] sx_q, sx_d;
    logic [7:0] sy_q, sy_d;
    logic [1:0] type_q, type_d;

    logic       scan_clear, scan_go;
    logic [3:0] px, py;
    logic       scan_last, scan_border;

    logic [9:0] x_sum;
    logic [8:0] y_sum;
    logic [2:0] type_col, pix_col;
    logic       in_plot;

    logic       flag_d, plot_d, busy_d, done_d;
    logic [3:0] index_d;
    logic [8:0] x_d;
    logic [7:0] y_d;
    logic [2:0] colour_d;

    sprite_scan u_scan (
        .clock  (clock),
        .resetn (resetn),
        .clear  (scan_clear),
        .go     (scan_go),
        .px     (px),
        .py     (py),
        .last   (scan_last),
        .border (scan_border)
    );

    // Next-state, table walk and stone field capture
    always_comb begin
        state_d    = state_q;
        qty_d      = qty_q;
        idx_d      = idx_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        type_d     = type_q;
        scan_clear = 1'b0;
        scan_go    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    qty_d   = quantity;
                    idx_d   = '0;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                state_d = (idx_q >= qty_q) ? StDone : StAddr;
            end
            StAddr:  state_d = StWait;
            StWait:  state_d = StLatch;
            StLatch: begin
                sx_d   = data[X_MSB:X_LSB];
                sy_d   = data[Y_MSB:Y_LSB];
                type_d = data[TYPE_MSB:TYPE_LSB];
                if (data[VIS_BIT]) begin
                    scan_clear = 1'b1;
                    state_d    = StPlot;
                end else begin
                    state_d = StNext;
                end
            end
            StPlot: begin
                scan_go = 1'b1;
                if (scan_last) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                // Bound check folded in here so each entry costs four overhead cycles
                idx_d   = idx_q + 4'd1;
                state_d = (({1'b0, idx_q} + 5'd1) >= {1'b0, qty_q}) ? StDone : StAddr;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Pixel address, clipping and colour selection for the current raster position
    always_comb begin
        x_sum   = {1'b0, sx_q} + {6'd0, px};
        y_sum   = {1'b0, sy_q} + {5'd0, py};
        in_plot = (state_q == StPlot);
        case (type_q)
            TYPE_STONE:          type_col = COL_STONE;
            TYPE_GOLD:           type_col = COL_GOLD;
            TYPE_DIAMOND, 2'b11: type_col = COL_DIAMOND;
            default:             type_col = COL_DIAMOND;
        endcase
        pix_col = type_col;
`ifdef STONE_DRAWER_OUTLINE_EN
        if (scan_border) begin
            pix_col = COL_OUTLINE;
        end
`endif
        flag_d   = (state_d inside {StAddr, StWait, StLatch, StPlot, StNext});
        index_d  = flag_d ? idx_d : '0;
        plot_d   = in_plot && in_screen(x_sum, y_sum);
        x_d      = in_plot ? x_sum[8:0] : '0;
        y_d      = in_plot ? y_sum[7:0] : '0;
        colour_d = in_plot ? pix_col : '0;
        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StDone);
    end

    // State, latches and registered outputs with synchronous reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q         <= StIdle;
            qty_q           <= '0;
            idx_q           <= '0;
            sx_q            <= '0;
            sy_q            <= '0;
            type_q          <= '0;
            draw_stone_flag <= 1'b0;
            draw_index      <= '0;
            x               <= '0;
            y               <= '0;
            colour          <= '0;
            plot            <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state_q         <= state_d;
            qty_q           <= qty_d;
            idx_q           <= idx_d;
            sx_q            <= sx_d;
            sy_q            <= sy_d;
            type_q          <= type_d;
            draw_stone_flag <= flag_d;
            draw_index      <= index_d;
            x               <= x_d;
            y               <= y_d;
            colour          <= colour_d;
            plot            <= plot_d;
            busy            <= busy_d;
            done            <= done_d;
        end
    end

    // Word fields the drawer does not consume (moving bit, spare bits)
`ifdef STONE_DRAWER_OUTLINE_EN
    logic unused_bits;
    assign unused_bits = ^{data[22:19], data[10:4], data[MOV_BIT]};
`else
    logic unused_bits;
    assign unused_bits = ^{data[22:19], data[10:4], data[MOV_BIT], scan_border, COL_OUTLINE};
`endif

endmodule

// File: tb/tb_stone_drawer.sv
// Self-checking bench for stone_drawer: table of single-stone frames plus
// hand-written multi-entry, empty-table, reset and back-to-back sequences.
module tb_stone_drawer;

    localparam logic [2:0] C_STONE = 3'b110;
    localparam logic [2:0] C_GOLD  = 3'b110;
    localparam logic [2:0] C_DIA   = 3'b011;
    localparam logic [2:0] C_OUT   = 3'b000;

    logic        clock, resetn, start;
    logic [3:0]  quantity;
    logic [31:0] data;
    logic        draw_stone_flag;
    logic [3:0]  draw_index;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot, busy, done;

    logic [31:0] mem [16];

    stone_drawer dut (
        .clock           (clock),
        .resetn          (resetn),
        .start           (start),
        .quantity        (quantity),
        .data            (data),
        .draw_stone_flag (draw_stone_flag),
        .draw_index      (draw_index),
        .x               (x),
        .y               (y),
        .colour          (colour),
        .plot            (plot),
        .busy            (busy),
        .done            (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Rope block RAM model: one clock read latency
    always @(posedge clock) data <= mem[draw_index];

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor state (owned by the monitor process; cleared via mon_reset)
    logic       mon_reset;
    int         nplots, oob, bad_col, n_outline, done_cnt;
    logic       flag_seen, prev_flag, probe_hit;
    logic [3:0] prev_idx;
    int         first_x, first_y, last_x, last_y;
    logic [2:0] first_col, last_col, probe_col;
    logic [3:0] reads[$];
    int         dx, dy;
    logic [2:0] ec;

    // Monitor configuration (written by the stimulus process only)
    logic       colchk;
    int         mon_sx, mon_sy, probe_x, probe_y;
    logic [2:0] exp_type_col;

    always @(negedge clock) begin
        if (mon_reset) begin
            nplots = 0; oob = 0; bad_col = 0; n_outline = 0; done_cnt = 0;
            flag_seen = 1'b0; prev_flag = 1'b0; prev_idx = '0; probe_hit = 1'b0;
            first_x = 0; first_y = 0; last_x = 0; last_y = 0;
            first_col = '0; last_col = '0; probe_col = '0;
            reads.delete();
        end else begin
            if (draw_stone_flag) flag_seen = 1'b1;
            if (draw_stone_flag && (!prev_flag || draw_index != prev_idx))
                reads.push_back(draw_index);
            prev_flag = draw_stone_flag;
            prev_idx  = draw_index;
            if (done) done_cnt++;
            if (plot) begin
                nplots++;
                if (nplots == 1) begin
                    first_x = int'(x); first_y = int'(y); first_col = colour;
                end
                last_x = int'(x); last_y = int'(y); last_col = colour;
                if (x >= 9'd320 || y >= 8'd240) oob++;
                if (colour == C_OUT) n_outline++;
                if (int'(x) == probe_x && int'(y) == probe_y) begin
                    probe_hit = 1'b1; probe_col = colour;
                end
                if (colchk) begin
                    dx = int'(x) - mon_sx;
                    dy = int'(y) - mon_sy;
                    ec = exp_type_col;
`ifdef STONE_DRAWER_OUTLINE_EN
                    if (dx == 0 || dx == 15 || dy == 0 || dy == 15) ec = C_OUT;
`endif
                    if (colour != ec) bad_col++;
                end
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(int sx, int sy, logic [1:0] t, logic v, logic m);
        logic [31:0] w;
        logic [8:0]  xs;
        logic [7:0]  ys;
        xs = 9'(sx);
        ys = 8'(sy);
        w = '0;
        w[31:23] = xs;
        w[18:11] = ys;
        w[3:2]   = t;
        w[1]     = v;
        w[0]     = m;
        return w;
    endfunction

    function automatic logic [2:0] tcol(logic [1:0] t);
        if (t == 2'b00) return C_STONE;
        if (t == 2'b01) return C_GOLD;
        return C_DIA;
    endfunction

    // Colour expected on a sprite border pixel of a stone of the given type colour
    function automatic logic [2:0] edge_col(logic [2:0] c);
`ifdef STONE_DRAWER_OUTLINE_EN
        return C_OUT;
`else
        return c;
`endif
    endfunction

    task automatic clear_mon();
        mon_reset = 1'b1;
        @(negedge clock);
        #1 mon_reset = 1'b0;
    endtask

    // Pulse start and count cycles from the start edge to the done pulse
    task automatic run_frame(input logic [3:0] q, output int lat);
        int n;
        quantity = q;
        start = 1'b1;
        @(posedge clock);
        n = 1;
        #1 start = 1'b0;
        while (!done && n < 3000) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!done) $display("FAIL frame_timeout: actual no done, required done");
        lat = n;
        repeat (3) @(negedge clock);
    endtask

    task automatic check_reads(input string name, input int n_exp);
        check({name, "_reads_len"}, reads.size(), n_exp);
        for (int i = 0; i < reads.size() && i < n_exp; i++)
            check({name, "_read_idx"}, reads[i], i);
    endtask

    typedef struct {
        int         sx;
        int         sy;
        logic [1:0] typ;
        logic       vis;
        logic       mov;
        int         exp_plots;
        int         exp_lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat;
        start = 1'b0; quantity = '0; resetn = 1'b0;
        colchk = 1'b0; mon_sx = 0; mon_sy = 0; probe_x = -1; probe_y = -1;
        exp_type_col = '0; mon_reset = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        vecs[0] = '{100, 50,  2'b01, 1'b1, 1'b0, 256, 262};
        vecs[1] = '{310, 230, 2'b00, 1'b1, 1'b0, 100, 262};
        vecs[2] = '{200, 100, 2'b10, 1'b0, 1'b0, 0,   6};
        vecs[3] = '{0,   0,   2'b11, 1'b1, 1'b1, 256, 262};
        vecs[4] = '{319, 239, 2'b00, 1'b1, 1'b0, 1,   262};
        vecs[5] = '{320, 0,   2'b01, 1'b1, 1'b0, 0,   262};
        vecs[6] = '{511, 200, 2'b10, 1'b1, 1'b0, 0,   262};
        vecs[7] = '{10,  235, 2'b01, 1'b1, 1'b0, 80,  262};
        vecs[8] = '{0,   250, 2'b00, 1'b1, 1'b0, 0,   262};

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_flag", draw_stone_flag, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_plot", plot, 0);
        check("rst_xyc", {x, y, colour}, 0);
        resetn = 1'b1;
        clear_mon();

        // Single-stone frames from the table
        foreach (vecs[i]) begin
            mem[0] = mk(vecs[i].sx, vecs[i].sy, vecs[i].typ, vecs[i].vis, vecs[i].mov);
            colchk = 1'b1; mon_sx = vecs[i].sx; mon_sy = vecs[i].sy;
            exp_type_col = tcol(vecs[i].typ);
            clear_mon();
            run_frame(4'd1, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_plots", i), nplots, vecs[i].exp_plots);
            check($sformatf("v%0d_offscreen", i), oob, 0);
            check($sformatf("v%0d_colours", i), bad_col, 0);
            check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
            if (vecs[i].exp_plots > 0) begin
                check($sformatf("v%0d_first_x", i), first_x, vecs[i].sx);
                check($sformatf("v%0d_first_y", i), first_y, vecs[i].sy);
                check($sformatf("v%0d_first_col", i), first_col, edge_col(tcol(vecs[i].typ)));
            end
        end
        colchk = 1'b0;

        // Three-entry table: gold, invisible, diamond
        mem[0] = 32'h3201_9006;
        mem[1] = mk(50, 50, 2'b00, 1'b0, 1'b0);
        mem[2] = mk(200, 100, 2'b10, 1'b1, 1'b0);
        clear_mon();
        run_frame(4'd3, lat);
        check("t3_latency", lat, 526);
        check("t3_plots", nplots, 512);
        check("t3_first_xy", first_x * 1000 + first_y, 100 * 1000 + 50);
        check("t3_first_col", first_col, edge_col(C_GOLD));
        check("t3_last_xy", last_x * 1000 + last_y, 215 * 1000 + 115);
        check("t3_last_col", last_col, edge_col(C_DIA));
        check_reads("t3", 3);

        // Empty table
        clear_mon();
        run_frame(4'd0, lat);
        check("q0_latency", lat, 2);
        check("q0_flag_seen", flag_seen, 0);
        check("q0_plots", nplots, 0);
        check("q0_done_cnt", done_cnt, 1);

        // Outline / interior colours for a stone at (40,40)
        mem[0] = mk(40, 40, 2'b00, 1'b1, 1'b0);
        probe_x = 41; probe_y = 41;
        clear_mon();
        run_frame(4'd1, lat);
        check("ol_latency", lat, 262);
        check("ol_corner_col", first_col, edge_col(C_STONE));
        check("ol_inner_hit", probe_hit, 1);
        check("ol_inner_col", probe_col, C_STONE);
`ifdef STONE_DRAWER_OUTLINE_EN
        check("ol_outline_cnt", n_outline, 60);
`else
        check("ol_outline_cnt", n_outline, 0);
`endif
        probe_x = -1; probe_y = -1;

        // Reset in the middle of PLOT, then restart from entry 0
        mem[0] = mk(100, 50, 2'b01, 1'b1, 1'b0);
        mem[1] = mk(20, 20, 2'b00, 1'b1, 1'b0);
        clear_mon();
        quantity = 4'd2;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (60) @(posedge clock);
        #1;
        check("mid_busy", busy, 1);
        check("mid_flag", draw_stone_flag, 1);
        @(negedge clock);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        check("rr_flag", draw_stone_flag, 0);
        check("rr_plot", plot, 0);
        check("rr_busy", busy, 0);
        check("rr_done", done, 0);
        check("rr_index", draw_index, 0);
        @(negedge clock);
        resetn = 1'b1;
        clear_mon();
        run_frame(4'd2, lat);
        check("rr_latency", lat, 522);
        check("rr_plots", nplots, 512);
        check_reads("rr", 2);

        // Start held high through the frame and coincident with done
        mem[0] = 32'h3201_9006;
        mem[1] = mk(50, 50, 2'b00, 1'b0, 1'b0);
        mem[2] = mk(200, 100, 2'b10, 1'b1, 1'b0);
        clear_mon();
        begin
            int n;
            quantity = 4'd3;
            start = 1'b1;
            @(posedge clock);
            n = 1;
            #1;
            while (!done && n < 3000) begin
                @(posedge clock);
                #1;
                n++;
            end
            check("b2b_latency", n, 526);
            @(posedge clock);
            #1 start = 1'b0;
            repeat (600) @(posedge clock);
            #1;
        end
        check("b2b_done_cnt", done_cnt, 1);
        check("b2b_plots", nplots, 512);
        check("b2b_busy_end", busy, 0);
        check_reads("b2b", 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout, required finish");
        $fatal(1, "watchdog");
    end

endmodule
